// File: rtl/divider_seq.sv
// Iterative restoring divider: 2*BITWIDTH-bit dividend by BITWIDTH-bit divisor,
// one quotient bit per enabled cycle, valid/ready handshake on both sides.
module divider_seq #(
  parameter int BITWIDTH = 32
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iEn,
  input  logic                    iClr,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [2*BITWIDTH-1:0]   iData0,
  input  logic [BITWIDTH-1:0]     iData1,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [BITWIDTH-1:0]     oQuot,
  output logic [BITWIDTH-1:0]     oRem,
  output logic                    oDivZero,
  output logic                    oOvf
);

  localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              nextState_s;
  logic [BITWIDTH-1:0] divisor_r;
  logic [BITWIDTH-1:0] remPart_r;
  logic [BITWIDTH-1:0] shift_r;
  logic [BITWIDTH-1:0] quot_r;
  logic [BITWIDTH-1:0] rem_r;
  logic [CW-1:0]       cnt_r;
  logic                valid_r;
  logic                divZero_r;
  logic                ovf_r;

  logic [BITWIDTH-1:0] dividendHi_s;
  logic                zeroDiv_s;
  logic                tooBig_s;
  logic                accept_s;
  logic [BITWIDTH:0]   trial_s;
  logic                geq_s;
  logic [BITWIDTH-1:0] remNext_s;
  logic [BITWIDTH-1:0] shiftNext_s;

  assign dividendHi_s = iData0[2*BITWIDTH-1:BITWIDTH];
  assign zeroDiv_s    = (iData1 == {BITWIDTH{1'b0}});
  assign tooBig_s     = (dividendHi_s >= iData1);
  assign oReady       = iRstN & iEn & (state_r == IDLE);
  assign accept_s     = iValid & oReady;

  assign oValid   = valid_r;
  assign oQuot    = quot_r;
  assign oRem     = rem_r;
  assign oDivZero = divZero_r;
  assign oOvf     = ovf_r;

  // One restoring step; the difference fits BITWIDTH bits because remPart_r < divisor_r
  always_comb begin
    trial_s     = {remPart_r, shift_r[BITWIDTH-1]};
    geq_s       = (trial_s >= {1'b0, divisor_r});
    remNext_s   = trial_s[BITWIDTH-1:0];
    shiftNext_s = {shift_r[BITWIDTH-2:0], geq_s};
    if (geq_s) begin
      remNext_s = trial_s[BITWIDTH-1:0] - divisor_r;
    end else begin
      remNext_s = trial_s[BITWIDTH-1:0];
    end
  end

  // Next-state decode
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (zeroDiv_s || tooBig_s) begin
            nextState_s = DONE;
          end else begin
            nextState_s = CALC;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == {CW{1'b0}}) begin
          nextState_s = DONE;
        end else begin
          nextState_s = CALC;
        end
      end
      DONE: begin
        if (iReady) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = DONE;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_r <= IDLE;
    end else if (iClr) begin
      state_r <= IDLE;
    end else if (iEn) begin
      state_r <= nextState_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Datapath and registered result outputs
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      divisor_r <= {BITWIDTH{1'b0}};
      remPart_r <= {BITWIDTH{1'b0}};
      shift_r   <= {BITWIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      quot_r    <= {BITWIDTH{1'b0}};
      rem_r     <= {BITWIDTH{1'b0}};
      valid_r   <= 1'b0;
      divZero_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (iClr) begin
      divisor_r <= {BITWIDTH{1'b0}};
      remPart_r <= {BITWIDTH{1'b0}};
      shift_r   <= {BITWIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      quot_r    <= {BITWIDTH{1'b0}};
      rem_r     <= {BITWIDTH{1'b0}};
      valid_r   <= 1'b0;
      divZero_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else if (iEn) begin
      case (state_r)
        IDLE: begin
          if (accept_s && zeroDiv_s) begin
            quot_r    <= {BITWIDTH{1'b1}};
            rem_r     <= iData0[BITWIDTH-1:0];
            divZero_r <= 1'b1;
            ovf_r     <= 1'b0;
            valid_r   <= 1'b1;
          end else if (accept_s && tooBig_s) begin
            quot_r    <= {BITWIDTH{1'b1}};
            rem_r     <= {BITWIDTH{1'b0}};
            divZero_r <= 1'b0;
            ovf_r     <= 1'b1;
            valid_r   <= 1'b1;
          end else if (accept_s) begin
            divisor_r <= iData1;
            remPart_r <= dividendHi_s;
            shift_r   <= iData0[BITWIDTH-1:0];
            cnt_r     <= CW'(BITWIDTH - 1);
          end else begin
            valid_r   <= 1'b0;
          end
        end
        CALC: begin
          remPart_r <= remNext_s;
          shift_r   <= shiftNext_s;
          cnt_r     <= cnt_r - CW'(1);
          if (cnt_r == {CW{1'b0}}) begin
            quot_r    <= shiftNext_s;
            rem_r     <= remNext_s;
            divZero_r <= 1'b0;
            ovf_r     <= 1'b0;
            valid_r   <= 1'b1;
          end else begin
            valid_r   <= 1'b0;
          end
        end
        DONE: begin
          if (iReady) begin
            valid_r <= 1'b0;
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed corner cases plus randomized
// operands with handshake/enable stalls against an arithmetic reference.
module tb_divider_seq;
  localparam int W = 32;

  logic           iClk = 1'b0;
  logic           iRstN;
  logic           iEn;
  logic           iClr;
  logic           iValid;
  logic           oReady;
  logic [2*W-1:0] iData0;
  logic [W-1:0]   iData1;
  logic           oValid;
  logic           iReady;
  logic [W-1:0]   oQuot;
  logic [W-1:0]   oRem;
  logic           oDivZero;
  logic           oOvf;

  int errCnt = 0;
  int chkCnt = 0;

  always #5 iClk = ~iClk;

  divider_seq #(.BITWIDTH(W)) dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr),
    .iValid(iValid), .oReady(oReady), .iData0(iData0), .iData1(iData1),
    .oValid(oValid), .iReady(iReady), .oQuot(oQuot), .oRem(oRem),
    .oDivZero(oDivZero), .oOvf(oOvf)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  // Reference: plain unsigned division with the saturating corner cases
  task automatic refDiv(input logic [63:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output logic ovf);
    longint unsigned aa, dd;
    aa = a;
    dd = {32'd0, d};
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a[31:0]; dz = 1'b1; ovf = 1'b0;
    end else if ((aa >> 32) >= dd) begin
      q = 32'hFFFF_FFFF; r = 32'd0; dz = 1'b0; ovf = 1'b1;
    end else begin
      q = 32'(aa / dd); r = 32'(aa % dd); dz = 1'b0; ovf = 1'b0;
    end
  endtask

  task automatic startOp(input logic [63:0] a, input logic [31:0] d);
    int n;
    iData0 = a;
    iData1 = d;
    iValid = 1'b1;
    n = 0;
    while (!oReady && n < 50) begin
      tick();
      n++;
    end
    if (!oReady) checkVal("readyTimeout", 64'd0, 64'd1);
    tick();
    iValid = 1'b0;
    iData0 = {$urandom, $urandom};
    iData1 = $urandom;
  endtask

  task automatic waitValid(input bit rndEn, output int n);
    n = 0;
    while (!oValid && n < 400) begin
      iEn = rndEn ? ($urandom_range(3) != 0) : 1'b1;
      tick();
      n++;
    end
    iEn = 1'b1;
    if (!oValid) checkVal("validTimeout", 64'd0, 64'd1);
  endtask

  task automatic consume;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
  endtask

  task automatic checkRes(input string tag, input logic [63:0] a, input logic [31:0] d);
    logic [31:0] q, r;
    logic dz, ovf;
    refDiv(a, d, q, r, dz, ovf);
    checkVal({tag, ".quot"}, 64'(oQuot), 64'(q));
    checkVal({tag, ".rem"}, 64'(oRem), 64'(r));
    checkVal({tag, ".dz"}, 64'(oDivZero), 64'(dz));
    checkVal({tag, ".ovf"}, 64'(oOvf), 64'(ovf));
  endtask

  initial begin
    int n;
    int seen;
    logic [63:0] a;
    logic [31:0] d;
    logic [31:0] hi;

    iRstN = 1'b0; iEn = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b0;
    iData0 = 64'd0; iData1 = 32'd0;
    #12;
    checkVal("rst.valid", 64'(oValid), 64'd0);
    checkVal("rst.ready", 64'(oReady), 64'd0);
    checkVal("rst.quot", 64'(oQuot), 64'd0);
    checkVal("rst.rem", 64'(oRem), 64'd0);
    checkVal("rst.flags", 64'({oDivZero, oOvf}), 64'd0);
    iRstN = 1'b1;
    tick();
    checkVal("idle.ready", 64'(oReady), 64'd1);

    // 200 / 20: latency and bubble in DONE
    startOp(64'd200, 32'd20);
    waitValid(1'b0, n);
    checkVal("lat200", 64'(n), 64'd32);
    checkVal("q200", 64'(oQuot), 64'd10);
    checkVal("r200", 64'(oRem), 64'd0);
    checkVal("f200", 64'({oDivZero, oOvf}), 64'd0);
    checkVal("doneReady", 64'(oReady), 64'd0);
    consume();
    checkVal("consumed.valid", 64'(oValid), 64'd0);
    checkVal("heldQuot", 64'(oQuot), 64'd10);

    // 1000003 / 7 with downstream stall
    startOp(64'd1000003, 32'd7);
    waitValid(1'b0, n);
    for (int i = 0; i < 5; i++) begin
      checkVal("hold.valid", 64'(oValid), 64'd1);
      checkVal("hold.quot", 64'(oQuot), 64'd142857);
      checkVal("hold.rem", 64'(oRem), 64'd4);
      tick();
    end
    consume();

    // Divide by zero resolves at the accept edge
    startOp(64'd99, 32'd0);
    checkVal("dz.valid", 64'(oValid), 64'd1);
    checkVal("dz.flag", 64'(oDivZero), 64'd1);
    checkVal("dz.quot", 64'(oQuot), 64'hFFFF_FFFF);
    checkVal("dz.rem", 64'(oRem), 64'd99);
    consume();

    // Quotient overflow
    startOp(64'h0000_0005_0000_0000, 32'd5);
    checkVal("ovf.valid", 64'(oValid), 64'd1);
    checkVal("ovf.flag", 64'(oOvf), 64'd1);
    checkVal("ovf.quot", 64'(oQuot), 64'hFFFF_FFFF);
    checkVal("ovf.dz", 64'(oDivZero), 64'd0);
    consume();

    // Enable low for 10 cycles mid-calculation
    startOp(64'h0000_0003_1234_5678, 32'h0000_1001);
    repeat (10) tick();
    iEn = 1'b0;
    repeat (10) tick();
    checkVal("stall.ready", 64'(oReady), 64'd0);
    iEn = 1'b1;
    waitValid(1'b0, n);
    checkVal("stall.lat", 64'(n + 20), 64'd42);
    checkRes("stall", 64'h0000_0003_1234_5678, 32'h0000_1001);
    consume();

    // Synchronous clear mid-calculation
    startOp(64'd123456789, 32'd3);
    repeat (5) tick();
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    checkVal("clr.ready", 64'(oReady), 64'd1);
    checkVal("clr.quot", 64'(oQuot), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (oValid) seen++;
      tick();
    end
    checkVal("clr.noValid", 64'(seen), 64'd0);

    // Randomized operands with enable and handshake stalls
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(9))
        0: begin d = 32'd0; a = {$urandom, $urandom}; end
        1: begin d = $urandom_range(1000) + 1; hi = d + $urandom_range(50); a = {hi, $urandom}; end
        2: begin d = 32'd1; a = {32'd0, $urandom}; end
        3: begin d = 32'hFFFF_FFFF; hi = $urandom; if (hi == 32'hFFFF_FFFF) hi = 32'd0; a = {hi, $urandom}; end
        default: begin
          d = $urandom >> $urandom_range(31);
          if (d == 32'd0) d = 32'd1;
          hi = $urandom % d;
          a = {hi, $urandom};
        end
      endcase
      repeat ($urandom_range(3)) tick();
      startOp(a, d);
      waitValid(1'b1, n);
      repeat ($urandom_range(3)) tick();
      checkRes("rnd", a, d);
      consume();
      checkVal("rnd.drop", 64'(oValid), 64'd0);
    end

    // Asynchronous reset mid-operation clears a held result immediately
    startOp(64'd1000003, 32'd7);
    waitValid(1'b0, n);
    consume();
    startOp(64'd500000, 32'd9);
    repeat (5) tick();
    #2;
    iRstN = 1'b0;
    #1;
    checkVal("arst.valid", 64'(oValid), 64'd0);
    checkVal("arst.quot", 64'(oQuot), 64'd0);
    checkVal("arst.rem", 64'(oRem), 64'd0);
    checkVal("arst.ready", 64'(oReady), 64'd0);
    #10;
    iRstN = 1'b1;
    tick();
    checkVal("arst.idle", 64'(oReady), 64'd1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
